// File: rtl/fetch_queue_ctrl_pkg.sv
// Shared constants and FSM encodings for the fetch queue controller.
// The optional stall counter is enabled by defining FETCH_STALL_CNT_EN.
package fetch_queue_ctrl_pkg;
  localparam int NLINES = 4;
  localparam int LINE_B = 16;
  localparam int PTR_W  = $clog2(NLINES);
  localparam int CNT_W  = PTR_W + 1;

  typedef enum logic [1:0] {
    FQ_IDLE = 2'd0,
    FQ_REQ  = 2'd1,
    FQ_DROP = 2'd2
  } fq_state_t;

  function automatic logic [31:0] line_base(input logic [31:0] addr);
    return {addr[31:4], 4'h0};
  endfunction
endpackage

// File: rtl/fetch_rotator.sv
// Combinational byte rotator: picks 16 consecutive bytes from two adjacent
// lines starting at byte offset off of the lower line.
module fetch_rotator
  import fetch_queue_ctrl_pkg::*;
(
  input  logic [8*LINE_B-1:0] lo,
  input  logic [8*LINE_B-1:0] hi,
  input  logic [3:0]          off,
  output logic [8*LINE_B-1:0] win
);
  logic [16*LINE_B-1:0] cat;
  assign cat = {hi, lo};

  genvar gi;
  generate
    for (gi = 0; gi < LINE_B; gi++) begin : g_byte
      logic [4:0] idx;
      assign idx = 5'(gi) + {1'b0, off};
      assign win[8*gi +: 8] = cat[{idx, 3'b000} +: 8];
    end
  endgenerate
endmodule

// File: rtl/fetch_queue_ctrl.sv
// Prefetch buffer sequencer: one-outstanding line fills, byte read pointer,
// 16-byte decode window and redirect handling. Optional FETCH_STALL_CNT_EN.
module fetch_queue_ctrl
  import fetch_queue_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         clr,
  input  logic         redirect_v,
  input  logic [31:0]  redirect_eip,
  input  logic         adv,
  input  logic [3:0]   adv_len,
  output logic         ic_req,
  output logic [31:0]  ic_addr,
  input  logic         ic_ack,
  input  logic [127:0] ic_data,
  output logic         ir_valid,
  output logic [127:0] ir,
  output logic [31:0]  cur_eip,
`ifdef FETCH_STALL_CNT_EN
  output logic [31:0]  stall_cnt,
`endif
  output logic [2:0]   line_cnt
);
  fq_state_t         state_reg;
  logic              ic_req_reg;
  logic [31:0]       ic_addr_reg;
  logic [27:0]       pend_addr_reg;
  logic [31:0]       cur_eip_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [CNT_W-1:0]  line_cnt_reg;
  logic [127:0]      line_mem [NLINES];

  logic [3:0]        off;
  logic [4:0]        off_sum;
  logic              adv_ok;
  logic              free;
  logic              fill_ok;
  logic [CNT_W-1:0]  cnt_after_free;
  logic [CNT_W-1:0]  cnt_next;
  logic [PTR_W-1:0]  rd_nxt;
  logic [127:0]      win;
  logic [31:0]       redir_line;

  assign off      = cur_eip_reg[3:0];
  // Compare without subtraction so an unfilled window never goes negative.
  assign ir_valid = {line_cnt_reg, 4'b0000} >= (7'(off) + 7'd16);
  assign adv_ok   = adv & ir_valid & (adv_len != 4'd0) & ~redirect_v;
  assign off_sum  = {1'b0, off} + {1'b0, adv_len};
  assign free     = adv_ok & off_sum[4];
  assign fill_ok  = (state_reg == FQ_REQ) & ic_ack & ~redirect_v;
  assign cnt_after_free = line_cnt_reg - CNT_W'(free);
  assign cnt_next       = line_cnt_reg + CNT_W'(fill_ok) - CNT_W'(free);
  assign rd_nxt         = rd_ptr_reg + PTR_W'(1);
  assign redir_line     = line_base(redirect_eip);

  fetch_rotator u_rot (
    .lo  (line_mem[rd_ptr_reg]),
    .hi  (line_mem[rd_nxt]),
    .off (off),
    .win (win)
  );

  assign ir       = ir_valid ? win : '0;
  assign ic_req   = ic_req_reg;
  assign ic_addr  = ic_addr_reg;
  assign cur_eip  = cur_eip_reg;
  assign line_cnt = line_cnt_reg;

  always_ff @(posedge clk) begin
    if (!clr && fill_ok) begin
      line_mem[wr_ptr_reg] <= ic_data;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_reg     <= FQ_IDLE;
      ic_req_reg    <= 1'b0;
      ic_addr_reg   <= '0;
      pend_addr_reg <= '0;
      cur_eip_reg   <= '0;
      rd_ptr_reg    <= '0;
      wr_ptr_reg    <= '0;
      line_cnt_reg  <= '0;
    end else if (redirect_v) begin
      line_cnt_reg <= '0;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      cur_eip_reg  <= redirect_eip;
      case (state_reg)
        FQ_IDLE: begin
          ic_addr_reg <= redir_line;
        end
        default: begin
          // An in-flight fill must still complete; its data is thrown away.
          if (ic_ack) begin
            state_reg   <= FQ_IDLE;
            ic_req_reg  <= 1'b0;
            ic_addr_reg <= redir_line;
          end else begin
            state_reg     <= FQ_DROP;
            pend_addr_reg <= redir_line[31:4];
          end
        end
      endcase
    end else begin
      line_cnt_reg <= cnt_next;
      if (adv_ok) cur_eip_reg <= cur_eip_reg + 32'(adv_len);
      if (free) rd_ptr_reg <= rd_nxt;
      if (fill_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      case (state_reg)
        FQ_IDLE: begin
          if (cnt_after_free < CNT_W'(NLINES)) begin
            state_reg  <= FQ_REQ;
            ic_req_reg <= 1'b1;
          end
        end
        FQ_REQ: begin
          if (ic_ack) begin
            state_reg   <= FQ_IDLE;
            ic_req_reg  <= 1'b0;
            ic_addr_reg <= ic_addr_reg + 32'(LINE_B);
          end
        end
        FQ_DROP: begin
          if (ic_ack) begin
            state_reg   <= FQ_IDLE;
            ic_req_reg  <= 1'b0;
            ic_addr_reg <= {pend_addr_reg, 4'h0};
          end
        end
        default: begin
          state_reg  <= FQ_IDLE;
          ic_req_reg <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt_reg;
  always_ff @(posedge clk) begin
    if (clr) begin
      stall_cnt_reg <= '0;
    end else if (!ir_valid && !redirect_v) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end
  assign stall_cnt = stall_cnt_reg;
`endif
endmodule

// File: tb/tb_fetch_queue_ctrl.sv
// Directed bench for fetch_queue_ctrl; line data byte k of line A is (A+k)[7:0].
module tb_fetch_queue_ctrl;
  logic         clk = 1'b0;
  logic         clr;
  logic         redirect_v;
  logic [31:0]  redirect_eip;
  logic         adv;
  logic [3:0]   adv_len;
  logic         ic_req;
  logic [31:0]  ic_addr;
  logic         ic_ack;
  logic [127:0] ic_data;
  logic         ir_valid;
  logic [127:0] ir;
  logic [31:0]  cur_eip;
  logic [2:0]   line_cnt;
`ifdef FETCH_STALL_CNT_EN
  logic [31:0]  stall_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fetch_queue_ctrl dut (
    .clk          (clk),
    .clr          (clr),
    .redirect_v   (redirect_v),
    .redirect_eip (redirect_eip),
    .adv          (adv),
    .adv_len      (adv_len),
    .ic_req       (ic_req),
    .ic_addr      (ic_addr),
    .ic_ack       (ic_ack),
    .ic_data      (ic_data),
    .ir_valid     (ir_valid),
    .ir           (ir),
    .cur_eip      (cur_eip),
`ifdef FETCH_STALL_CNT_EN
    .stall_cnt    (stall_cnt),
`endif
    .line_cnt     (line_cnt)
  );

  function automatic logic [127:0] win_at(input logic [31:0] e);
    logic [127:0] w;
    for (int k = 0; k < 16; k++) w[8*k +: 8] = 8'(e + 32'(k));
    return w;
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr = 1'b1; redirect_v = 1'b0; redirect_eip = '0; adv = 1'b0; adv_len = '0;
    ic_ack = 1'b0; ic_data = '0;
    tick(); tick();
    check("rst_ic_req", 128'(ic_req), 128'd0);
    check("rst_ic_addr", 128'(ic_addr), 128'd0);
    check("rst_ir_valid", 128'(ir_valid), 128'd0);
    check("rst_ir", ir, 128'd0);
    check("rst_cur_eip", 128'(cur_eip), 128'd0);
    check("rst_line_cnt", 128'(line_cnt), 128'd0);

    // 1: redirect to 1000, fill two lines
    clr = 1'b0; redirect_v = 1'b1; redirect_eip = 32'h0000_1000;
    tick();
    redirect_v = 1'b0;
    check("t1_cur_eip", 128'(cur_eip), 128'h1000);
    check("t1_addr_redir", 128'(ic_addr), 128'h1000);
    tick();
    check("t1_req0", 128'(ic_req), 128'd1);
    check("t1_addr0", 128'(ic_addr), 128'h1000);
    ic_ack = 1'b1; ic_data = win_at(32'h1000);
    tick();
    ic_ack = 1'b0;
    check("t1_cnt1", 128'(line_cnt), 128'd1);
    check("t1_irv", 128'(ir_valid), 128'd1);
    check("t1_ir_b0", 128'(ir[7:0]), 128'h00);
    check("t1_req_gap", 128'(ic_req), 128'd0);
    tick();
    check("t1_req1", 128'(ic_req), 128'd1);
    check("t1_addr1", 128'(ic_addr), 128'h1010);
    ic_ack = 1'b1; ic_data = win_at(32'h1010);
    tick();
    ic_ack = 1'b0;
    check("t1_cnt2", 128'(line_cnt), 128'd2);
    check("t1_ir", ir, win_at(32'h1000));

    // 2: advance 5 then 15
    adv = 1'b1; adv_len = 4'd5;
    tick();
    check("t2_eip5", 128'(cur_eip), 128'h1005);
    check("t2_cnt_a", 128'(line_cnt), 128'd2);
    check("t2_ir_a", ir, win_at(32'h1005));
    adv_len = 4'd15;
    tick();
    adv = 1'b0;
    check("t2_eip14", 128'(cur_eip), 128'h1014);
    check("t2_cnt_b", 128'(line_cnt), 128'd1);
    check("t2_irv", 128'(ir_valid), 128'd0);
    check("t2_ir0", ir, 128'd0);
    check("t2_req", 128'(ic_req), 128'd1);
    check("t2_addr", 128'(ic_addr), 128'h1020);

    // 3: fill until full, then free one line
    ic_ack = 1'b1; ic_data = win_at(32'h1020);
    tick();
    ic_ack = 1'b0;
    tick();
    check("t3_addr30", 128'(ic_addr), 128'h1030);
    ic_ack = 1'b1; ic_data = win_at(32'h1030);
    tick();
    ic_ack = 1'b0;
    tick();
    check("t3_addr40", 128'(ic_addr), 128'h1040);
    ic_ack = 1'b1; ic_data = win_at(32'h1040);
    tick();
    ic_ack = 1'b0;
    check("t3_cnt4", 128'(line_cnt), 128'd4);
    for (int i = 0; i < 3; i++) begin
      check("t3_full_noreq", 128'(ic_req), 128'd0);
      tick();
    end
    check("t3_ir", ir, win_at(32'h1014));
    adv = 1'b1; adv_len = 4'd12;
    tick();
    adv = 1'b0;
    check("t3_reissue", 128'(ic_req), 128'd1);
    check("t3_addr50", 128'(ic_addr), 128'h1050);
    check("t3_cnt3", 128'(line_cnt), 128'd3);
    check("t3_ir20", ir, win_at(32'h1020));
    // same-cycle fill and free, across pointer wrap
    adv = 1'b1; adv_len = 4'd1;
    tick();
    adv_len = 4'd15; ic_ack = 1'b1; ic_data = win_at(32'h1050);
    tick();
    adv = 1'b0; ic_ack = 1'b0;
    check("t3_both_cnt", 128'(line_cnt), 128'd3);
    check("t3_both_eip", 128'(cur_eip), 128'h1030);
    check("t3_both_ir", ir, win_at(32'h1030));
    tick();
    check("t3_req60", 128'(ic_addr), 128'h1060);

    // 4: redirect with a fill pending; its data must be dropped
    redirect_v = 1'b1; redirect_eip = 32'h0000_2007;
    tick();
    redirect_v = 1'b0;
    check("t4_drop_req", 128'(ic_req), 128'd1);
    check("t4_drop_addr", 128'(ic_addr), 128'h1060);
    check("t4_eip", 128'(cur_eip), 128'h2007);
    check("t4_cnt0", 128'(line_cnt), 128'd0);
    check("t4_irv0", 128'(ir_valid), 128'd0);
    tick();
    ic_ack = 1'b1; ic_data = {16{8'hAA}};
    tick();
    ic_ack = 1'b0;
    check("t4_aa_dropped", 128'(line_cnt), 128'd0);
    check("t4_req_off", 128'(ic_req), 128'd0);
    check("t4_addr2000", 128'(ic_addr), 128'h2000);
    tick();
    ic_ack = 1'b1; ic_data = win_at(32'h2000);
    tick();
    ic_ack = 1'b0;
    check("t4_irv_one", 128'(ir_valid), 128'd0);
    tick();
    check("t4_addr2010", 128'(ic_addr), 128'h2010);
    ic_ack = 1'b1; ic_data = win_at(32'h2010);
    tick();
    ic_ack = 1'b0;
    check("t4_ir_b0", 128'(ir[7:0]), 128'h07);
    check("t4_ir", ir, win_at(32'h2007));

    // 5: ignored advances
    adv = 1'b1; adv_len = 4'd0;
    tick();
    check("t5_len0", 128'(cur_eip), 128'h2007);
    adv_len = 4'd3; redirect_v = 1'b1; redirect_eip = 32'h0000_3000;
    tick();
    redirect_v = 1'b0;
    check("t5_with_redir", 128'(cur_eip), 128'h3000);
    check("t5_old_addr", 128'(ic_addr), 128'h2020);
    adv_len = 4'd4;
    tick();
    adv = 1'b0;
    check("t5_not_valid", 128'(cur_eip), 128'h3000);
    redirect_v = 1'b1; redirect_eip = 32'h0000_3105;
    tick();
    redirect_v = 1'b0;
    check("t5_drop_redir_eip", 128'(cur_eip), 128'h3105);
    check("t5_drop_redir_addr", 128'(ic_addr), 128'h2020);
    ic_ack = 1'b1; ic_data = {16{8'h55}};
    tick();
    ic_ack = 1'b0;
    check("t5_pend_addr", 128'(ic_addr), 128'h3100);
    check("t5_cnt0", 128'(line_cnt), 128'd0);
    tick();
    check("t6_req_pre", 128'(ic_req), 128'd1);

    // 6: reset mid-fill, ack afterwards is ignored
    clr = 1'b1;
    tick();
    check("t6_req", 128'(ic_req), 128'd0);
    check("t6_addr", 128'(ic_addr), 128'd0);
    check("t6_eip", 128'(cur_eip), 128'd0);
    check("t6_irv", 128'(ir_valid), 128'd0);
    clr = 1'b0; ic_ack = 1'b1; ic_data = win_at(32'h3100);
    tick();
    ic_ack = 1'b0;
    check("t6_cnt", 128'(line_cnt), 128'd0);
    check("t6_ir", ir, 128'd0);
    check("t6_eip_after", 128'(cur_eip), 128'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
